// File: rtl/piso_scan_ctrl.sv
// piso_scan_ctrl: scans one or more cascaded 8-bit parallel-in/serial-out
// shift registers (74HC165 style). A scan parallel-loads the chain and samples
// the serial output for BIT_CYC cycles per bit. Between bits it issues one
// shift pulse. The assembled word is then offered with a valid/ready handshake.
module piso_scan_ctrl #(
  parameter int N_DEV   = 1,
  parameter int BIT_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  output logic                 busy,
  output logic [8*N_DEV-1:0]   data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 piso_load_n,
  output logic                 piso_clken_n,
  input  logic                 piso_q
);

  localparam int W   = 8 * N_DEV;
  localparam int BCW = $clog2(W) + 1;

  // Bit index of the final bit of a scan, and the last cycle spent sampling a bit.
  localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);
  localparam logic [3:0]     LAST_CYC = 4'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SAMPLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]       cyc_cnt_q, cyc_cnt_d;
  logic [W-1:0]     shreg_q, shreg_d;
  logic [W-1:0]     data_q, data_d;
  logic [W-1:0]     shreg_in;

  // The first bit captured ends up in the MSB after W left shifts.
  assign shreg_in = {shreg_q[W-2:0], piso_q};

  // State, counter and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      cyc_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
    end
  end

  // Next-state logic and PISO control outputs, decoded from the current state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    busy         = 1'b1;
    data_valid   = 1'b0;
    piso_load_n  = 1'b1;
    piso_clken_n = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
          cyc_cnt_d = '0;
        end
      end

      S_LOAD: begin
        piso_load_n = 1'b0;
        bit_cnt_d   = '0;
        cyc_cnt_d   = '0;
        state_d     = S_SAMPLE;
      end

      S_SAMPLE: begin
        if (cyc_cnt_q == LAST_CYC) begin
          shreg_d   = shreg_in;
          bit_cnt_d = bit_cnt_q + BCW'(1);
          cyc_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            // Publish the completed word; it is held until the next scan finishes.
            data_d  = shreg_in;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 4'd1;
        end
      end

      S_SHIFT: begin
        piso_clken_n = 1'b0;
        state_d      = S_SAMPLE;
      end

      S_DONE: begin
        data_valid = 1'b1;
        if (data_ready) begin
          if (cont) begin
            state_d   = S_LOAD;
            bit_cnt_d = '0;
            cyc_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_piso_scan_ctrl.sv
// Bench for piso_scan_ctrl: two instances (single device, BIT_CYC=1 and two
// cascaded devices, BIT_CYC=2). Each instance drives a behavioural 74HC165
// chain. A timeline model predicts every output on every cycle. Directed
// scenarios add hand-computed literal checks.
module tb_piso_scan_ctrl;

  localparam int N0 = 1, BC0 = 1;
  localparam int N1 = 2, BC1 = 2;
  localparam int W0 = 8 * N0;
  localparam int W1 = 8 * N1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  v_rst, v_start, v_cont, v_ready, v_q;
  logic [1:0]  v_busy, v_valid, v_load_n, v_clken_n;
  logic [15:0] par_d [2];
  logic [W0-1:0] dout0;
  logic [W1-1:0] dout1;
  logic [15:0] chain [2] = '{16'h0, 16'h0};

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  piso_scan_ctrl #(.N_DEV(N0), .BIT_CYC(BC0)) dut0 (
    .clk(clk), .rst(v_rst[0]), .start(v_start[0]), .cont(v_cont[0]),
    .busy(v_busy[0]), .data_out(dout0), .data_valid(v_valid[0]),
    .data_ready(v_ready[0]), .piso_load_n(v_load_n[0]),
    .piso_clken_n(v_clken_n[0]), .piso_q(v_q[0])
  );

  piso_scan_ctrl #(.N_DEV(N1), .BIT_CYC(BC1)) dut1 (
    .clk(clk), .rst(v_rst[1]), .start(v_start[1]), .cont(v_cont[1]),
    .busy(v_busy[1]), .data_out(dout1), .data_valid(v_valid[1]),
    .data_ready(v_ready[1]), .piso_load_n(v_load_n[1]),
    .piso_clken_n(v_clken_n[1]), .piso_q(v_q[1])
  );

  function automatic logic [15:0] dout(int i);
    return (i == 0) ? {8'h00, dout0} : dout1;
  endfunction

  function automatic int width_of(int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic int bc_of(int i);
    return (i == 0) ? BC0 : BC1;
  endfunction

  // Cycles from the start-accepting edge to data_valid.
  function automatic int lat_of(int i);
    return 1 + width_of(i) * bc_of(i) + (width_of(i) - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural 74HC165 chain: parallel load while LOAD is low, else shift toward Q.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!v_load_n[i])        chain[i] <= par_d[i];
      else if (!v_clken_n[i])  chain[i] <= chain[i] << 1;
    end
  end
  assign v_q[0] = chain[0][W0-1];
  assign v_q[1] = chain[1][W1-1];

  // Timeline model: m_w is the cycle position since the accepting edge
  // (-1 idle, 0 load, 1..lat-1 sampling/shifting, lat = word offered).
  int          m_w    [2] = '{-1, -1};
  logic [15:0] m_word [2] = '{16'h0, 16'h0};
  logic [15:0] m_data [2] = '{16'h0, 16'h0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (v_rst[i]) begin
        m_w[i]    <= -1;
        m_data[i] <= 16'h0;
      end else if (m_w[i] < 0) begin
        if (v_start[i]) m_w[i] <= 0;
      end else if (m_w[i] < lat_of(i)) begin
        if (m_w[i] == 0) m_word[i] <= par_d[i];
        if (m_w[i] == lat_of(i) - 1) m_data[i] <= m_word[i];
        m_w[i] <= m_w[i] + 1;
      end else if (v_ready[i]) begin
        m_w[i] <= v_cont[i] ? 0 : -1;
      end
    end
  end

  function automatic logic e_busy(int i);
    return m_w[i] >= 0;
  endfunction

  function automatic logic e_load_n(int i);
    return !(m_w[i] == 0);
  endfunction

  // A shift pulse closes each group of BIT_CYC sample cycles, except after the last bit.
  function automatic logic e_clken_n(int i);
    if (m_w[i] >= 1 && m_w[i] < lat_of(i))
      return !(((m_w[i] - 1) % (bc_of(i) + 1)) == bc_of(i));
    return 1'b1;
  endfunction

  function automatic logic e_valid(int i);
    return m_w[i] == lat_of(i);
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i),    v_busy[i],    e_busy(i));
        chk($sformatf("load_n[%0d]", i),  v_load_n[i],  e_load_n(i));
        chk($sformatf("clken_n[%0d]", i), v_clken_n[i], e_clken_n(i));
        chk($sformatf("valid[%0d]", i),   v_valid[i],   e_valid(i));
        chk($sformatf("data[%0d]", i),    dout(i),      m_data[i]);
        chk($sformatf("excl[%0d]", i),    v_load_n[i] | v_clken_n[i], 1'b1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_scan(input int i, input logic [15:0] d);
    par_d[i]   = d;
    v_start[i] = 1'b1;
  endtask

  // Wait (bounded) for data_valid, counting LOAD and shift pulses on the way.
  task automatic wait_valid(input int i, output int lat, output int loads,
                            output int shifts, output logic [15:0] word);
    int k;
    bit got;
    k = 0; got = 0; loads = 0; shifts = 0; lat = -1;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      v_start[i] = 1'b0;
      if (!v_load_n[i])  loads++;
      if (!v_clken_n[i]) shifts++;
      if (v_valid[i]) begin
        got = 1;
        lat = k - 1;
      end
    end
    chk($sformatf("valid_seen[%0d]", i), v_valid[i], 1'b1);
    word = dout(i);
  endtask

  task automatic handshake(input int i);
    logic [15:0] w;
    w = dout(i);
    v_ready[i] = 1'b1;
    @(negedge clk);
    v_ready[i] = 1'b0;
    chk($sformatf("idle_after_hs[%0d]", i), v_busy[i], 1'b0);
    $display("scan dut%0d word=%h", i, w);
  endtask

  initial begin
    int lat, loads, shifts;
    logic [15:0] word;

    v_rst = 2'b11; v_start = 2'b00; v_cont = 2'b00; v_ready = 2'b00;
    par_d[0] = 16'h0; par_d[1] = 16'h0;

    // Reset held for two edges.
    tick(2);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_load_n",  v_load_n[i],  1'b1);
      chk("rst_clken_n", v_clken_n[i], 1'b1);
      chk("rst_busy",    v_busy[i],    1'b0);
      chk("rst_valid",   v_valid[i],   1'b0);
      chk("rst_data",    dout(i),      16'h0);
    end
    v_rst = 2'b00;

    // data_ready while nothing is offered has no effect.
    v_ready = 2'b11;
    tick(3);
    chk("ready_idle_busy0", v_busy[0], 1'b0);
    chk("ready_idle_busy1", v_busy[1], 1'b0);
    v_ready = 2'b00;

    // Single scan, one device.
    start_scan(0, 16'h00AB);
    wait_valid(0, lat, loads, shifts, word);
    chk("single_lat",    lat,    16);
    chk("single_loads",  loads,  1);
    chk("single_shifts", shifts, 7);
    chk("single_word",   word,   16'h00AB);

    // Backpressure with an ignored start in the middle.
    for (int c = 0; c < 5; c++) begin
      v_start[0] = (c == 2);
      @(negedge clk);
      chk("bp_valid",  v_valid[0],  1'b1);
      chk("bp_data",   dout(0),     16'h00AB);
      chk("bp_load_n", v_load_n[0], 1'b1);
    end
    v_start[0] = 1'b0;
    handshake(0);
    tick(2);
    chk("hold_data", dout(0), 16'h00AB);

    // Two cascaded devices, BIT_CYC=2.
    start_scan(1, 16'h9766);
    wait_valid(1, lat, loads, shifts, word);
    chk("casc_lat",    lat,    48);
    chk("casc_loads",  loads,  1);
    chk("casc_shifts", shifts, 15);
    chk("casc_word",   word,   16'h9766);
    handshake(1);

    // Continuous mode: back-to-back scans with new parallel data.
    v_cont[0] = 1'b1; v_ready[0] = 1'b1;
    start_scan(0, 16'h00AB);
    wait_valid(0, lat, loads, shifts, word);
    chk("cont_word1", word, 16'h00AB);
    $display("scan dut0 word=%h", word);
    par_d[0] = 16'h0066;
    @(negedge clk);
    chk("cont_reload", v_load_n[0], 1'b0);
    wait_valid(0, lat, loads, shifts, word);
    chk("cont_word2",   word,   16'h0066);
    chk("cont_shifts2", shifts, 7);
    v_cont[0] = 1'b0;
    $display("scan dut0 word=%h", word);
    @(negedge clk);
    chk("cont_stop_idle", v_busy[0], 1'b0);
    v_ready[0] = 1'b0;

    // Reset after three bits captured, with start asserted in the same cycle.
    start_scan(0, 16'h005A);
    @(negedge clk);
    v_start[0] = 1'b0;
    tick(6);
    v_rst[0] = 1'b1; v_start[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",    v_busy[0],    1'b0);
    chk("mid_rst_load_n",  v_load_n[0],  1'b1);
    chk("mid_rst_clken_n", v_clken_n[0], 1'b1);
    chk("mid_rst_valid",   v_valid[0],   1'b0);
    chk("mid_rst_data",    dout(0),      16'h0);
    v_rst[0] = 1'b0; v_start[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_start", v_busy[0], 1'b0);
    start_scan(0, 16'h0097);
    wait_valid(0, lat, loads, shifts, word);
    chk("rescan_lat",  lat,  16);
    chk("rescan_word", word, 16'h0097);
    handshake(0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_scan_ctrl.md
PISO_SCAN_CTRL -- requirements
Module: piso_scan_ctrl

Interface
REQ-001 Parameter N_DEV, default 1: number of cascaded 8-bit PISO registers scanned; legal 1..4.
REQ-002 Parameter BIT_CYC, default 1: clock cycles spent in SAMPLE per bit; legal 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one scan; sampled only in IDLE.
REQ-006 cont  input  1  continuous mode; when 1, a new scan begins immediately after each handshake.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 data_out  output  8*N_DEV  assembled scan word; first bit sampled goes to MSB.
REQ-009 data_valid  output  1  data_out holds a complete scan.
REQ-010 data_ready  input  1  consumer accepts data_out.
REQ-011 piso_load_n  output  1  drives PISO LOAD; active-low parallel load.
REQ-012 piso_clken_n  output  1  drives PISO clken; 0 = shift enabled, 1 = inhibit.
REQ-013 piso_q  input  1  PISO serial output Q; the bit nearest the output is presented first.

Function
REQ-014 FSM states: IDLE, LOAD, SAMPLE, SHIFT, DONE; one-hot or binary is acceptable.
REQ-015 IDLE: piso_load_n=1, piso_clken_n=1, busy=0; start=1 -> LOAD, and bit counter and cycle counter clear.
REQ-016 LOAD: piso_load_n=0 for exactly 1 cycle, piso_clken_n=1 -> SAMPLE.
REQ-017 SAMPLE: both PISO controls inactive for BIT_CYC cycles.
REQ-018 SAMPLE capture: on the last SAMPLE cycle, piso_q shifts into the LSB of the internal shift register (left shift) and the bit counter increments.
REQ-019 SAMPLE exit: if the captured bit was bit 8*N_DEV-1 -> DONE; otherwise -> SHIFT.
REQ-020 SHIFT: piso_clken_n=0 for exactly 1 cycle, piso_load_n=1 -> SAMPLE.
REQ-021 piso_load_n and piso_clken_n shall never be 0 in the same cycle.
REQ-022 Shift pulses per scan: exactly 8*N_DEV-1; no shift pulse after the last bit.
REQ-023 DONE: data_out is driven from the shift register and data_valid=1; both stay stable until the handshake (data_valid & data_ready at a rising edge).
REQ-024 Handshake exit: cont=0 -> IDLE; cont=1 -> LOAD directly.
REQ-025 Latency: data_valid rises 1 + 8*N_DEV*BIT_CYC + (8*N_DEV-1) cycles after the edge that accepts start (16 cycles for N_DEV=1, BIT_CYC=1).
REQ-026 start while busy is ignored and is not queued.
REQ-027 data_out keeps its last value after the handshake until the next DONE.
REQ-028 data_ready while data_valid=0 has no effect.
REQ-029 Counters: bit counter width is ceil(log2(8*N_DEV))+1; cycle counter is 4 bits; neither wraps within a scan.

Reset
REQ-030 With rst=1 at an edge: state=IDLE, piso_load_n=1, piso_clken_n=1, busy=0, data_valid=0, data_out=0, counters=0.
REQ-031 Reset mid-scan aborts the scan; no partial data is presented, and the next start performs a complete scan beginning with LOAD.
REQ-032 rst has priority over start, data_ready and cont in the same cycle.

Verification
REQ-033 Reset: hold rst for 2 cycles -> load_n=1, clken_n=1, busy=0, data_valid=0, data_out=0.
REQ-034 Single scan (behavioural 74HC165 model, N_DEV=1, BIT_CYC=1, D=0xAB), start pulse -> load_n low 1 cycle, 7 single-cycle clken_n pulses, data_valid at +16 cycles, data_out=0xAB.
REQ-035 Backpressure: data_ready low for 5 cycles after valid -> data_valid=1 and data_out=0xAB stable throughout; start pulsed meanwhile -> no LOAD; ready=1 -> IDLE next cycle.
REQ-036 Cascade (N_DEV=2, first-out byte 0x97, second 0x66) -> 15 shift pulses, data_out=0x9766.
REQ-037 Continuous (cont=1, ready=1, D changes 0xAB->0x66 between scans) -> load_n low in the cycle after the handshake; consecutive words 0xAB then 0x66.
REQ-038 Reset mid-scan: rst asserted after 3 bits captured -> idle values next cycle; a following start with D=0x97 -> data_out=0x97.
